// File: rtl/cnt_fifo_pkg.sv
// Shared helpers for the counter-sourced FIFO: address-width wrapper, parameter sanity check, parity.
package cnt_fifo_pkg;

  // Widest data word the parity helper folds; wider DW would be truncated.
  localparam int PAR_MAXW = 128;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit cfg_ok(input int depth, input int afull_th, input int aempty_th);
    return is_pow2(depth) && (depth >= 4) && (afull_th <= depth) && (aempty_th < afull_th);
  endfunction

  // Even parity bit: the stored word {p, data} always has an even number of ones.
  function automatic logic even_parity(input logic [PAR_MAXW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/cnt_fifo_stream_ram.sv
// Simple dual-port RAM for cnt_fifo_stream: one write port, one registered read-first read port.
module cnt_fifo_stream_ram #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto block RAM; only the output register is reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= wdata;
  end

  // Output register only loads on an accepted read, so rdata holds its last value otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      rdata <= '0;
    else if (rd_en) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cnt_fifo_stream.sv
// Counter-sourced synchronous FIFO with registered status flags and occupancy.
// Optional macro CNT_FIFO_PARITY_EN: stores even parity per word and adds a par_err output.
module cnt_fifo_stream
  import cnt_fifo_pkg::*;
#(
  parameter int DW        = 20,
  parameter int DEPTH     = 64,
  parameter int STEP      = 1,
  parameter int CNT_INIT  = 0,
  parameter int AFULL_TH  = 60,
  parameter int AEMPTY_TH = 4,
  localparam int AW       = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          down,
  input  logic          clr,
  input  logic          re,
  output logic [DW-1:0] q,
  output logic          q_valid,
  output logic          full,
  output logic          empty,
  output logic          afull,
  output logic          aempty,
  output logic          stall,
  output logic          underflow,
`ifdef CNT_FIFO_PARITY_EN
  output logic          par_err,
`endif
  output logic [AW:0]   wrcnt
);

  if (!cfg_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_cfg
    $error("cnt_fifo_stream: DEPTH must be a power of two >= 4, AFULL_TH <= DEPTH, AEMPTY_TH < AFULL_TH");
  end

`ifdef CNT_FIFO_PARITY_EN
  localparam int WW = DW + 1;
`else
  localparam int WW = DW;
`endif

  localparam logic [AW:0]   FULL_V   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AFULL_V  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0]   AEMPTY_V = (AW+1)'(AEMPTY_TH);
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] STEP_V   = DW'(STEP);
  localparam logic [DW-1:0] INIT_V   = DW'(CNT_INIT);

  logic [DW-1:0] cnt;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count_nxt;
  logic          wr_ok, rd_ok;
  logic [WW-1:0] wdata, rdata;

  // Flags are from the current cycle, so a full FIFO refuses the write even if a read frees a slot.
  assign wr_ok = en & ~full  & ~clr;
  assign rd_ok = re & ~empty & ~clr;

  // NOTE: default assignment first so every path drives count_nxt and no latch is inferred.
  always_comb begin
    count_nxt = wrcnt;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = wrcnt + CNT_ONE;
      2'b01:   count_nxt = wrcnt - CNT_ONE;
      default: count_nxt = wrcnt;
    endcase
    if (clr) count_nxt = '0;
  end

`ifdef CNT_FIFO_PARITY_EN
  assign wdata   = {even_parity(PAR_MAXW'(cnt)), cnt};
  assign par_err = q_valid & (^rdata);
`else
  assign wdata   = cnt;
`endif
  assign q = rdata[DW-1:0];

  cnt_fifo_stream_ram #(
    .WIDTH (WW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .wr_en (wr_ok),
    .waddr (wptr),
    .wdata (wdata),
    .rd_en (rd_ok),
    .raddr (rptr),
    .rdata (rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= INIT_V;
      wptr      <= '0;
      rptr      <= '0;
      wrcnt     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      stall     <= 1'b0;
      underflow <= 1'b0;
      q_valid   <= 1'b0;
    end else begin
      wrcnt     <= count_nxt;
      full      <= (count_nxt == FULL_V);
      empty     <= (count_nxt == '0);
      afull     <= (count_nxt >= AFULL_V);
      aempty    <= (count_nxt <= AEMPTY_V);
      stall     <= en & full & ~clr;
      underflow <= re & empty & ~clr;
      q_valid   <= rd_ok;
      if (clr) begin
        cnt  <= INIT_V;
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_ok) begin
          wptr <= wptr + PTR_ONE;
          cnt  <= down ? (cnt - STEP_V) : (cnt + STEP_V);
        end
        if (rd_ok) rptr <= rptr + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_cnt_fifo_stream.sv
// Directed self-checking bench for cnt_fifo_stream at default parameters (DW=20, DEPTH=64).
// With CNT_FIFO_PARITY_EN defined, also exercises the parity error path.
module tb_cnt_fifo_stream;

  logic        clk = 1'b0;
  logic        rstn, en, down, clr, re;
  logic [19:0] q;
  logic        q_valid, full, empty, afull, aempty, stall, underflow;
  logic [6:0]  wrcnt;
`ifdef CNT_FIFO_PARITY_EN
  logic        par_err;
`endif

  int checks = 0;
  int errors = 0;

  cnt_fifo_stream dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .down      (down),
    .clr       (clr),
    .re        (re),
    .q         (q),
    .q_valid   (q_valid),
    .full      (full),
    .empty     (empty),
    .afull     (afull),
    .aempty    (aempty),
    .stall     (stall),
    .underflow (underflow),
`ifdef CNT_FIFO_PARITY_EN
    .par_err   (par_err),
`endif
    .wrcnt     (wrcnt)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; down = 1'b0; clr = 1'b0; re = 1'b0;
    tick(); tick();
    checks++; if (q !== 20'h0)     begin errors++; $display("FAIL reset_q: got %h exp 0", q); end
    checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_q_valid: got %b exp 0", q_valid); end
    checks++; if ({full, empty, afull, aempty} !== 4'b0101) begin errors++; $display("FAIL reset_flags: got %b exp 0101", {full, empty, afull, aempty}); end
    checks++; if ({stall, underflow} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b exp 00", {stall, underflow}); end
    checks++; if (wrcnt !== 7'd0)   begin errors++; $display("FAIL reset_wrcnt: got %0d exp 0", wrcnt); end
`ifdef CNT_FIFO_PARITY_EN
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b exp 0", par_err); end
`endif
    rstn = 1'b1;
    tick();
    checks++; if ({empty, wrcnt} !== {1'b1, 7'd0}) begin errors++; $display("FAIL post_reset: empty=%b wrcnt=%0d exp 1/0", empty, wrcnt); end
  endtask

  // 70 cycles of en: 64 accepted, then 6 stall pulses; drain 0..63, then 64 after en resumes.
  task automatic test_fill_drain();
    int n;
    int stall_n = 0;
    en = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      tick();
      n = (k < 64) ? k : 64;
      checks++; if (wrcnt !== 7'(n))    begin errors++; $display("FAIL fill_wrcnt[%0d]: got %0d exp %0d", k, wrcnt, n); end
      checks++; if (full !== (k >= 64)) begin errors++; $display("FAIL fill_full[%0d]: got %b exp %b", k, full, k >= 64); end
      checks++; if (afull !== (n >= 60)) begin errors++; $display("FAIL fill_afull[%0d]: got %b exp %b", k, afull, n >= 60); end
      checks++; if (aempty !== (n <= 4)) begin errors++; $display("FAIL fill_aempty[%0d]: got %b exp %b", k, aempty, n <= 4); end
      checks++; if (stall !== (k >= 65)) begin errors++; $display("FAIL fill_stall[%0d]: got %b exp %b", k, stall, k >= 65); end
      if (stall === 1'b1) stall_n++;
    end
    checks++; if (stall_n != 6) begin errors++; $display("FAIL stall_count: got %0d exp 6", stall_n); end
    en = 1'b0; re = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      checks++; if (q_valid !== 1'b1)  begin errors++; $display("FAIL drain_valid[%0d]: got %b exp 1", i, q_valid); end
      checks++; if (q !== 20'(i))      begin errors++; $display("FAIL drain_q[%0d]: got %0d exp %0d", i, q, i); end
      checks++; if (wrcnt !== 7'(63 - i)) begin errors++; $display("FAIL drain_wrcnt[%0d]: got %0d exp %0d", i, wrcnt, 63 - i); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b exp 1", empty); end
    re = 1'b0; en = 1'b1;
    tick();
    checks++; if ({wrcnt, q_valid} !== {7'd1, 1'b0}) begin errors++; $display("FAIL resume_wr: wrcnt=%0d q_valid=%b exp 1/0", wrcnt, q_valid); end
    en = 1'b0; re = 1'b1;
    tick();
    checks++; if ({q_valid, q} !== {1'b1, 20'd64}) begin errors++; $display("FAIL resume_q: valid=%b q=%0d exp 1/64", q_valid, q); end
    re = 1'b0;
    tick();
    checks++; if ({q_valid, q} !== {1'b0, 20'd64}) begin errors++; $display("FAIL q_hold: valid=%b q=%0d exp 0/64", q_valid, q); end
  endtask

  // Read on empty: underflow pulse only, read pointer untouched (next write 65 is read back).
  task automatic test_underflow();
    re = 1'b1;
    tick();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_pulse: got %b exp 1", underflow); end
    checks++; if ({wrcnt, q_valid, empty} !== {7'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL uf_state: wrcnt=%0d valid=%b empty=%b exp 0/0/1", wrcnt, q_valid, empty); end
    re = 1'b0; en = 1'b1;
    tick();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b exp 0", underflow); end
    en = 1'b0; re = 1'b1;
    tick();
    checks++; if ({q_valid, q} !== {1'b1, 20'd65}) begin errors++; $display("FAIL uf_rptr: valid=%b q=%0d exp 1/65", q_valid, q); end
    re = 1'b0;
    tick();
  endtask

  // Full plus en plus re: read wins, write refused with stall, full drops.
  task automatic test_full_rw();
    en = 1'b1;
    for (int k = 0; k < 64; k++) tick();
    checks++; if ({full, wrcnt} !== {1'b1, 7'd64}) begin errors++; $display("FAIL frw_full: full=%b wrcnt=%0d exp 1/64", full, wrcnt); end
    re = 1'b1;
    tick();
    checks++; if (stall !== 1'b1)   begin errors++; $display("FAIL frw_stall: got %b exp 1", stall); end
    checks++; if ({full, afull, wrcnt} !== {1'b0, 1'b1, 7'd63}) begin errors++; $display("FAIL frw_count: full=%b afull=%b wrcnt=%0d exp 0/1/63", full, afull, wrcnt); end
    checks++; if ({q_valid, q} !== {1'b1, 20'd66}) begin errors++; $display("FAIL frw_q: valid=%b q=%0d exp 1/66", q_valid, q); end
    en = 1'b0; re = 1'b0;
    tick();
    checks++; if ({stall, wrcnt} !== {1'b0, 7'd63}) begin errors++; $display("FAIL frw_after: stall=%b wrcnt=%0d exp 0/63", stall, wrcnt); end
  endtask

  // Occupancy 10, simultaneous read and write for 200 cycles: pointers wrap, data ascends by 1.
  task automatic test_back_to_back();
    clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    checks++; if (wrcnt !== 7'd10) begin errors++; $display("FAIL b2b_prefill: got %0d exp 10", wrcnt); end
    re = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      checks++; if (wrcnt !== 7'd10) begin errors++; $display("FAIL b2b_wrcnt[%0d]: got %0d exp 10", i, wrcnt); end
      checks++; if ({q_valid, q} !== {1'b1, 20'(i)}) begin errors++; $display("FAIL b2b_q[%0d]: valid=%b q=%0d exp 1/%0d", i, q_valid, q, i); end
    end
    en = 1'b0; re = 1'b0;
    tick();
  endtask

  // Down-counting wraps modulo 2^20.
  task automatic test_down();
    logic [19:0] exp_q [3];
    exp_q[0] = 20'h00000; exp_q[1] = 20'hFFFFF; exp_q[2] = 20'hFFFFE;
    clr = 1'b1;
    tick();
    clr = 1'b0; down = 1'b1; en = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    en = 1'b0; down = 1'b0; re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({q_valid, q} !== {1'b1, exp_q[i]}) begin errors++; $display("FAIL down_q[%0d]: valid=%b q=%h exp 1/%h", i, q_valid, q, exp_q[i]); end
    end
    re = 1'b0;
    tick();
  endtask

  // clr overrides en/re, empties the FIFO, holds q and restarts the counter.
  task automatic test_clr();
    en = 1'b1;
    for (int k = 0; k < 30; k++) tick();
    checks++; if ({wrcnt, aempty} !== {7'd30, 1'b0}) begin errors++; $display("FAIL clr_pre: wrcnt=%0d aempty=%b exp 30/0", wrcnt, aempty); end
    clr = 1'b1; re = 1'b1;
    tick();
    checks++; if ({wrcnt, empty, aempty, full, afull} !== {7'd0, 4'b1100}) begin errors++; $display("FAIL clr_state: wrcnt=%0d flags=%b exp 0/1100", wrcnt, {empty, aempty, full, afull}); end
    checks++; if ({q_valid, stall, underflow} !== 3'b000) begin errors++; $display("FAIL clr_pulses: got %b exp 000", {q_valid, stall, underflow}); end
    checks++; if (q !== 20'hFFFFE) begin errors++; $display("FAIL clr_q_hold: got %h exp fffff e", q); end
    clr = 1'b0; re = 1'b0; en = 1'b1;
    tick();
    en = 1'b0; re = 1'b1;
    tick();
    checks++; if ({q_valid, q, wrcnt} !== {1'b1, 20'd0, 7'd0}) begin errors++; $display("FAIL clr_init: valid=%b q=%0d wrcnt=%0d exp 1/0/0", q_valid, q, wrcnt); end
    re = 1'b0;
    tick();
  endtask

`ifdef CNT_FIFO_PARITY_EN
  // Flip a stored bit of word 0 and expect par_err with its read; the next clean word reads without error.
  task automatic test_parity();
    clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1;
    tick(); tick();
    en = 1'b0;
    dut.u_ram.mem[0][0] = ~dut.u_ram.mem[0][0];
    re = 1'b1;
    tick();
    checks++; if ({q_valid, par_err} !== 2'b11) begin errors++; $display("FAIL par_err_hit: valid=%b par_err=%b exp 11", q_valid, par_err); end
    tick();
    checks++; if ({q_valid, par_err, q} !== {2'b10, 20'd1}) begin errors++; $display("FAIL par_err_clean: valid=%b par_err=%b q=%0d exp 10/1", q_valid, par_err, q); end
    re = 1'b0;
    tick();
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_err_idle: got %b exp 0", par_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_underflow();
    test_full_rw();
    test_back_to_back();
    test_down();
    test_clr();
`ifdef CNT_FIFO_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
